conv_out_quant: RTL

Stream requantizer and framing checker on the output side of the serial convolution stage. It consumes the wide signed accumulator stream (data plus valid/sop/eop/sof/eof) and performs round-half-up, arithmetic right shift, optional ReLU and saturation. It re-emits the result at activation width with identical framing and a per-word channel index, so the next layer can take it directly. A passive checker verifies the line/frame structure and raises sticky error flags.

---
 rtl/conv_out_quant.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/conv_out_quant.sv
// Output-side requantizer for the serial conv stage: round, shift, ReLU, saturate,
// with framing passed through alongside a per-word channel index and a sticky framing checker.
module conv_out_quant #(
   parameter int DATA_IN_WIDTH  = 24,
   parameter int DATA_OUT_WIDTH = 8,
   parameter int SHIFT          = 8,
   parameter int RELU           = 1,
   parameter int CHANNEL_NUM    = 16,
   parameter int LINE_WORDS     = 3584,
   localparam int CH_W          = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             valid_i,
   input  logic [DATA_IN_WIDTH-1:0]         data_i,
   input  logic                             sop_i,
   input  logic                             eop_i,
   input  logic                             sof_i,
   input  logic                             eof_i,
   input  logic                             err_clr_i,
   output logic signed [DATA_OUT_WIDTH-1:0] data_o,
   output logic                             data_valid_o,
   output logic                             sop_o,
   output logic                             eop_o,
   output logic                             sof_o,
   output logic                             eof_o,
   output logic [CH_W-1:0]                  ch_o,
   output logic                             err_len_o,
   output logic                             err_frame_o
);

   localparam int DI    = DATA_IN_WIDTH;
   localparam int DO    = DATA_OUT_WIDTH;
   localparam int CNT_W = $clog2(LINE_WORDS + 2);
   localparam logic signed [DI:0] RND  = (DI+1)'((64'd1 << SHIFT) >> 1);
   localparam logic signed [DI:0] SMAX = (DI+1)'((64'd1 << (DO - 1)) - 64'd1);
   localparam logic signed [DI:0] SMIN = ~SMAX;
   localparam logic [CNT_W-1:0]   LW      = CNT_W'(LINE_WORDS);
   localparam logic [CH_W-1:0]    CH_LAST = CH_W'(CHANNEL_NUM - 1);

   typedef struct packed {
      logic sop;
      logic eop;
      logic sof;
      logic eof;
   } flags_t;

   typedef enum logic [1:0] {IDLE, LINE, FRAME} state_t;

   logic [2:0]            vld_pipe_q, vld_pipe_d;
   flags_t [2:0]          flg_pipe_q, flg_pipe_d;
   logic [2:0][CH_W-1:0]  ch_pipe_q, ch_pipe_d;
   logic signed [DI:0]    r_q, r_d, s_q, s_d;
   logic signed [DO-1:0]  q_q, q_d;
   logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d, ch_word;
   flags_t                flg_in;
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      word_cnt_q, word_cnt_d, word_inc;
   logic                  err_len_q, err_len_d, err_frame_q, err_frame_d;
   logic                  set_len, set_frame;

   always_comb begin
      flg_in   = {sop_i, eop_i, sof_i, eof_i} & {4{valid_i}};
      ch_word  = sop_i ? '0 : ch_cnt_q;
      ch_cnt_d = ch_cnt_q;
      if (valid_i)
         ch_cnt_d = (ch_word == CH_LAST) ? '0 : ch_word + 1'b1;
      vld_pipe_d = {vld_pipe_q[1:0], valid_i};
      flg_pipe_d = {flg_pipe_q[1:0], flg_in};
      ch_pipe_d  = {ch_pipe_q[1:0], (valid_i ? ch_word : CH_W'(0))};
      // One extra bit of headroom keeps the rounding add from wrapping.
      r_d = $signed({data_i[DI-1], data_i}) + RND;
      s_d = r_q >>> SHIFT;
      if (RELU != 0 && s_d[DI])
         s_d = '0;
      q_d = s_q[DO-1:0];
      if (s_q > SMAX)
         q_d = SMAX[DO-1:0];
      else if (s_q < SMIN)
         q_d = SMIN[DO-1:0];
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      set_len    = 1'b0;
      set_frame  = 1'b0;
      // Count saturates one past LINE_WORDS so an overlong line trips err_len only once.
      word_inc   = (word_cnt_q > LW) ? word_cnt_q : word_cnt_q + 1'b1;
      if (valid_i) begin
         if ((eof_i && !eop_i) || (sof_i && !sop_i))
            set_frame = 1'b1;
         if (sop_i) begin
            case (state_q)
               IDLE:    if (!sof_i) set_frame = 1'b1;
               FRAME:   if (sof_i)  set_frame = 1'b1;
               default: set_frame = 1'b1;
            endcase
            if (state_q != IDLE || sof_i) begin
               state_d    = LINE;
               word_cnt_d = CNT_W'(1);
            end
         end else if (state_q == LINE) begin
            word_cnt_d = word_inc;
            if (!eop_i && word_cnt_q == LW)
               set_len = 1'b1;
         end else begin
            set_frame = 1'b1;
         end
         // eop closes whatever line is open after the sop handling above.
         if (eop_i && state_d == LINE) begin
            if (word_cnt_d != LW)
               set_len = 1'b1;
            state_d    = eof_i ? IDLE : FRAME;
            word_cnt_d = '0;
         end
      end
      err_len_d   = set_len   | (err_len_q   & ~err_clr_i);
      err_frame_d = set_frame | (err_frame_q & ~err_clr_i);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe_q  <= '0;
         flg_pipe_q  <= '0;
         ch_pipe_q   <= '0;
         r_q         <= '0;
         s_q         <= '0;
         q_q         <= '0;
         ch_cnt_q    <= '0;
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         err_len_q   <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         flg_pipe_q  <= flg_pipe_d;
         ch_pipe_q   <= ch_pipe_d;
         r_q         <= r_d;
         s_q         <= s_d;
         q_q         <= q_d;
         ch_cnt_q    <= ch_cnt_d;
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         err_len_q   <= err_len_d;
         err_frame_q <= err_frame_d;
      end
   end

   assign data_o       = q_q;
   assign data_valid_o = vld_pipe_q[2];
   assign sop_o        = flg_pipe_q[2].sop;
   assign eop_o        = flg_pipe_q[2].eop;
   assign sof_o        = flg_pipe_q[2].sof;
   assign eof_o        = flg_pipe_q[2].eof;
   assign ch_o         = ch_pipe_q[2];
   assign err_len_o    = err_len_q;
   assign err_frame_o  = err_frame_q;

endmodule
